// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: default width and FSM encoding.
package seq_signed_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_signed_divider_cond_negate.sv
// Conditional two's-complement negation: out = neg ? ~in + 1 : in.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring signed divider: one shift/subtract step per cycle, quotient truncates
// toward zero, remainder takes the sign of the dividend.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   div_q, div_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             q_sign_q, q_sign_d;
    logic             r_sign_q, r_sign_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exception_q, exception_d;

    // Operand magnitudes carry one extra bit so that |MIN| is representable.
    logic [WIDTH:0] a_ext, b_ext, abs_a, abs_b;
    assign a_ext = {data_operandA[WIDTH-1], data_operandA};
    assign b_ext = {data_operandB[WIDTH-1], data_operandB};

    cond_negate #(.WIDTH(WIDTH + 1)) u_abs_a (
        .in (a_ext),
        .neg(data_operandA[WIDTH-1]),
        .out(abs_a)
    );

    cond_negate #(.WIDTH(WIDTH + 1)) u_abs_b (
        .in (b_ext),
        .neg(data_operandB[WIDTH-1]),
        .out(abs_b)
    );

    // One restoring step; rem stays below |B|, so the trial difference fits WIDTH+1 signed bits.
    logic [WIDTH:0]   rem_shift, trial, step_rem;
    logic [WIDTH-1:0] step_quo;
    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial     = rem_shift - div_q;
    assign step_rem  = trial[WIDTH] ? rem_shift : trial;
    assign step_quo  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    logic [WIDTH-1:0] fix_quo, fix_rem;

    cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .in (step_quo),
        .neg(q_sign_q),
        .out(fix_quo)
    );

    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .in (step_rem[WIDTH-1:0]),
        .neg(r_sign_q),
        .out(fix_rem)
    );

    // NOTE: every signal gets a default first so no path through the case leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        div_d       = div_q;
        quo_d       = quo_q;
        q_sign_d    = q_sign_q;
        r_sign_d    = r_sign_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exception_d = exception_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (ctrl_DIV) begin
                    rem_d    = '0;
                    quo_d    = abs_a[WIDTH-1:0];
                    div_d    = abs_b;
                    q_sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    r_sign_d = data_operandA[WIDTH-1];
                    ovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                               (data_operandB == '1);
                    cnt_d    = '0;
                    if (data_operandB == '0) begin
                        state_d     = DONE;
                        result_d    = '0;
                        remainder_d = data_operandA;
                        exception_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                // Results are captured on the edge entering DONE so they are valid with resultRDY.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    result_d    = fix_quo;
                    remainder_d = fix_rem;
                    exception_d = ovf_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            q_sign_q    <= q_sign_d;
            r_sign_q    <= r_sign_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exception_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed self-checking bench for seq_signed_divider: latency, signs, exceptions, reset, back-to-back.
module tb_seq_signed_divider;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        exception;
    logic        rdy;
    logic        busy;

    int tests_run;
    int tests_failed;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (op_a),
        .data_operandB (op_b),
        .data_result   (result),
        .data_remainder(remainder),
        .data_exception(exception),
        .data_resultRDY(rdy),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Called #1 after an edge in cycle 'first'; returns the cycle in which rdy is seen (-1 on timeout).
    task automatic wait_rdy(input int first, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = first; k <= first + 45; k++) begin
            if (rdy) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clock); #1;
        end
    endtask

    // Start edge is cycle 0; returns in the rdy cycle.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cycles);
        ctrl_DIV = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        wait_rdy(1, lat, busy_cycles);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({result, remainder, exception, rdy, busy} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h/%h/%b/%b/%b want all zero",
                     result, remainder, exception, rdy, busy);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_div(32'd100, 32'd7, lat, bc);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d want 33", lat);
        end
        tests_run++;
        if (bc !== 32) begin
            tests_failed++;
            $display("FAIL basic_busy_cycles: got %0d want 32", bc);
        end
        tests_run++;
        if ({result, remainder, exception, busy} !== {32'd14, 32'd2, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_100_div_7: got q=%0d r=%0d exc=%b busy=%b want 14 2 0 0",
                     result, remainder, exception, busy);
        end
        @(posedge clock); #1;
        tests_run++;
        if ({rdy, result, remainder} !== {1'b0, 32'd14, 32'd2}) begin
            tests_failed++;
            $display("FAIL basic_pulse_hold: got rdy=%b q=%0d r=%0d want 0 14 2", rdy, result, remainder);
        end
    endtask

    task automatic test_signs();
        int lat, bc;
        run_div(32'hFFFF_FF9C, 32'd7, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0}) begin
            tests_failed++;
            $display("FAIL neg_dividend: got lat=%0d q=%h r=%h exc=%b want 33 fffffff2 fffffffe 0",
                     lat, result, remainder, exception);
        end
        @(posedge clock); #1;
        run_div(32'd100, 32'hFFFF_FFF9, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'hFFFF_FFF2, 32'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL neg_divisor: got lat=%0d q=%h r=%h exc=%b want 33 fffffff2 2 0",
                     lat, result, remainder, exception);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_div(32'd5, 32'd0, lat, bc);
        tests_run++;
        if ({lat, bc} !== {32'd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL div0_latency: got lat=%0d busy=%0d want 1 0", lat, bc);
        end
        tests_run++;
        if ({result, remainder, exception} !== {32'd0, 32'd5, 1'b1}) begin
            tests_failed++;
            $display("FAIL div0_values: got q=%h r=%h exc=%b want 0 5 1", result, remainder, exception);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'h8000_0000, 32'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL min_div_m1: got lat=%0d q=%h r=%h exc=%b want 33 80000000 0 1",
                     lat, result, remainder, exception);
        end
        @(posedge clock); #1;
        run_div(32'h8000_0000, 32'd2, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'hC000_0000, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL min_div_2: got lat=%0d q=%h r=%h exc=%b want 33 c0000000 0 0",
                     lat, result, remainder, exception);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        ctrl_DIV = 1'b1;
        op_a = 32'd1000;
        op_b = 32'd3;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if ({result, remainder, exception, rdy, busy} !== 67'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h/%h/%b/%b/%b want all zero",
                     result, remainder, exception, rdy, busy);
        end
        reset = 1'b1;
        wait_rdy(11, lat, bc);
        tests_run++;
        if ({lat, bc} !== {-32'sd1, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_mid_no_rdy: got rdy_cycle=%0d busy=%0d want -1 0", lat, bc);
        end
        run_div(32'd9, 32'd3, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'd3, 32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL after_reset_9_div_3: got lat=%0d q=%0d r=%0d exc=%b want 33 3 0 0",
                     lat, result, remainder, exception);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        ctrl_DIV = 1'b1;
        op_a = 32'd200;
        op_b = 32'd9;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        op_a = 32'd7;
        op_b = 32'd7;
        repeat (4) @(posedge clock);
        #1;
        ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        wait_rdy(6, lat, bc);
        tests_run++;
        if ({lat, result, remainder, exception} !== {32'd33, 32'd22, 32'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d exc=%b want 33 22 2 0",
                     lat, result, remainder, exception);
        end
        run_div(32'hFFFF_FFCE, 32'd6, lat, bc);
        tests_run++;
        if ({lat, bc, result, remainder} !== {32'd33, 32'd32, 32'hFFFF_FFF8, 32'hFFFF_FFFE}) begin
            tests_failed++;
            $display("FAIL b2b_second: got lat=%0d busy=%0d q=%h r=%h want 33 32 fffffff8 fffffffe",
                     lat, bc, result, remainder);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        ctrl_DIV     = 1'b0;
        op_a         = '0;
        op_b         = '0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
